npc_sram: RTL
=============

# npc_sram

AXI responder terminating the high-address port of `npc_xbar` (`sram_w_m2s`/`sram_w_s2m`, `sram_r_m2s`/`sram_r_s2m`) in the simulation top. It holds a word-addressed memory and services bursts on independent read and write engines. Reads return data after a programmable latency, so the bench can stress the LSU/IFU with back-pressure. There are no response codes and no IDs; the channel structs carry no resp/id fields.

## Interface
- `BASE_ADDR`, default 32'h8000_0000: first byte address backed by the memory.
- `MEM_WORDS`, default 65536: number of 32-bit words; must be a power of two.
- `READ_LATENCY`, default 1: cycles from the AR handshake to the first `rvalid`; legal range 1..15.
- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `w_m2s` in `axi_w_m2s_t`: awvalid/awaddr/awlen/awsize/awburst, wvalid/wdata/wstrb/wlast, bready.
- `w_s2m` out `axi_w_s2m_t`: awready, wready, bvalid.
- `r_m2s` in `axi_r_m2s_t`: arvalid/araddr/arlen/arsize/arburst, rready.
- `r_s2m` out `axi_r_s2m_t`: arready, rvalid, rdata[31:0], rlast.

## Operation
- **Write FSM**
  - W_IDLE: awready=1. When awvalid, latch addr/len/size/burst, clear the beat count, go to W_DATA.
  - W_DATA: wready=1. On each wvalid&wready, write the enabled byte lanes of the current word and advance the address.
  - Leave W_DATA after beat awlen+1 (beat count == awlen), regardless of wlast; go to W_RESP.
  - W_RESP: bvalid=1 until bready, then W_IDLE.
- **Read FSM**
  - R_IDLE: arready=1. When arvalid, latch the burst.
  - If READ_LATENCY==1 go straight to R_DATA; otherwise go to R_WAIT with counter = READ_LATENCY-1.
  - R_WAIT: decrement the counter; go to R_DATA on the cycle the counter reaches 1.
  - rdata is registered. It is loaded from the current address on entry to R_DATA and on every accepted non-last beat.
  - R_DATA: rvalid=1. rlast=1 on beat arlen. On rvalid&rready&rlast, return to R_IDLE.
- **Address update**
  - INCR: addr += 1<<min(size,2).
  - FIXED: addr unchanged.
  - WRAP is treated as INCR.
  - Word index = (addr-BASE_ADDR)>>2. Lane selection is by wstrb only.
- **Range**
  - Address < BASE_ADDR or >= BASE_ADDR+4*MEM_WORDS is out of range.
  - Out-of-range reads return 32'h0. Out-of-range writes are dropped. The handshakes still complete normally.
  - A burst may cross out of range mid-burst; the rule is applied per beat.
- **Engine independence**
  - Read and write engines are fully independent and may be active in the same cycle.
  - If a write commits to word X on the same edge that rdata loads from X, rdata gets the old value (read-first).
- Memory contents are not reset.

## Timing
- **Reset**
  - While reset is high: awready, wready, bvalid, arready, rvalid and rlast are all 0, and rdata = 0.
  - Both FSMs go to IDLE, so awready=arready=1 on the first cycle after reset deasserts.
  - Reset mid-burst abandons the burst. No bvalid or rvalid is produced for it, and beats already written remain written.
- **Write timing**
  - AW accepted at edge N: wready is high from cycle N+1.
  - Last W beat at edge M: bvalid is high from cycle M+1.
  - Single-beat write occupancy is 3 cycles minimum (AW, W, B). The next AW is accepted the cycle after the B handshake.
- **Read timing**
  - AR accepted at edge N: rvalid is first high in cycle N+READ_LATENCY.
  - Beats are back-to-back while rready=1; throughput is one beat per cycle.
  - With rready low, rvalid, rdata and rlast hold stable.
- awready and wready are never high together. arready and rvalid are never high together.
- Beat counters are 8 bits and address arithmetic is 32-bit modulo; no overflow flags.

## Test plan
- **Single write then read:** AW 0x8000_0010 len0 size2, W 0xDEADBEEF strb 4'hF -> bvalid at AW edge+2. Then AR to the same address with READ_LATENCY=3 -> rvalid exactly 3 cycles after the AR edge, rdata=0xDEADBEEF, rlast=1.
- **Byte strobes:** write 0x11223344 full, then 0xAABBCCDD with strb 4'b0101 -> read returns 0x11BB33DD.
- **INCR burst with back-pressure:** write a len3 burst of 1,2,3,4 at 0x8000_0100. Read it back while toggling rready every cycle -> data 1,2,3,4 in order, rdata stable while stalled, rlast only on beat 4.
- **FIXED burst:** len2 FIXED write of 5,6,7 -> the single word holds 7; neighbouring word unchanged.
- **Out of range and concurrency:** read of 0x8000_0000+4*MEM_WORDS -> rdata 0. A write to the same address completes with bvalid and leaves memory unchanged. A simultaneous read and write to different words both complete with no mutual stall.
- **Reset mid-burst:** assert reset during beat 2 of a len3 read -> rvalid 0 on the next cycle, arready 1 one cycle after reset release. A new read of beat 1's word returns the correct data.

Source files
------------

// File: rtl/npc_sram.sv
// npc_sram: AXI responder for the high-address port of npc_xbar.
// Word-addressed memory with independent burst read and write engines.
// Reads return their first beat READ_LATENCY cycles after the AR handshake.
//
// Ports
//   clock, reset       : rising-edge clock, synchronous active-high reset
//   aw*/w*/bready (in) : write address, write data and response-ready
//   awready, wready,
//   bvalid (out)       : write handshakes (no resp/id)
//   ar*/rready (in)    : read address and read-ready
//   arready, rvalid,
//   rdata, rlast (out) : read handshakes and data (no resp/id)
//
// The channel structs are flattened into one port per field so the module
// stands alone without a shared package; field names are the struct member
// names.
module npc_sram #(
  parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
  parameter int unsigned MEM_WORDS    = 65536,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  // write channels
  input  logic        awvalid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        wvalid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        bready,
  output logic        awready,
  output logic        wready,
  output logic        bvalid,
  // read channels
  input  logic        arvalid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        rready,
  output logic        arready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic        rlast
);

  localparam int unsigned IW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;

  logic [31:0] mem [MEM_WORDS];

  // Burst length is taken from awlen; wlast carries no extra information.
  logic unused_wlast;
  assign unused_wlast = wlast;

  function automatic logic in_range(input logic [31:0] a);
    return (a >= BASE_ADDR) &&
           ({32'd0, a - BASE_ADDR} < (64'(MEM_WORDS) * 64'd4));
  endfunction

  function automatic logic [IW-1:0] word_idx(input logic [31:0] a);
    return IW'((a - BASE_ADDR) >> 2);
  endfunction

  // FIXED holds the address; INCR and WRAP both step by the beat size,
  // capped at one word.
  function automatic logic [31:0] next_addr(input logic [31:0] a,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    logic [31:0] step;
    step = (size >= 3'd2) ? 32'd4 : ((size == 3'd1) ? 32'd2 : 32'd1);
    return (burst == 2'b00) ? a : a + step;
  endfunction

  // ---------------------------------------------------------------- write
  w_state_t    w_state, w_next;
  logic [31:0] w_addr;
  logic [7:0]  w_len, w_cnt;
  logic [2:0]  w_size;
  logic [1:0]  w_burst;
  logic        aw_fire, w_fire, w_last_beat;

  assign aw_fire     = awvalid && awready;
  assign w_fire      = wvalid && wready;
  assign w_last_beat = (w_cnt == w_len);

  always_ff @(posedge clock) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (awvalid)               w_next = W_DATA;
      W_DATA:  if (wvalid && w_last_beat) w_next = W_RESP;
      W_RESP:  if (bready)                w_next = W_IDLE;
      default:                            w_next = W_IDLE;
    endcase
  end

  always_comb begin
    awready = !reset && (w_state == W_IDLE);
    wready  = !reset && (w_state == W_DATA);
    bvalid  = !reset && (w_state == W_RESP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
    end else if (aw_fire) begin
      w_addr  <= awaddr;
      w_len   <= awlen;
      w_size  <= awsize;
      w_burst <= awburst;
      w_cnt   <= '0;
    end else if (w_fire) begin
      w_addr  <= next_addr(w_addr, w_size, w_burst);
      w_cnt   <= w_cnt + 8'd1;
    end
  end

  // Memory is deliberately left without reset.
  always_ff @(posedge clock) begin
    if (w_fire && in_range(w_addr)) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  r_state_t    r_state, r_next;
  logic [31:0] r_addr, rd_addr, rdata_q;
  logic [7:0]  r_len, r_cnt;
  logic [2:0]  r_size;
  logic [1:0]  r_burst;
  logic [3:0]  lat_cnt;
  logic        ar_fire, r_fire, r_last_beat, rd_load;

  assign ar_fire     = arvalid && arready;
  assign r_fire      = rvalid && rready;
  assign r_last_beat = (r_cnt == r_len);

  always_ff @(posedge clock) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (arvalid) r_next = (READ_LATENCY == 1) ? R_DATA : R_WAIT;
      R_WAIT:  if (lat_cnt == 4'd1)         r_next = R_DATA;
      R_DATA:  if (rready && r_last_beat)   r_next = R_IDLE;
      default:                              r_next = R_IDLE;
    endcase
  end

  always_comb begin
    arready = !reset && (r_state == R_IDLE);
    rvalid  = !reset && (r_state == R_DATA);
    rlast   = !reset && (r_state == R_DATA) && r_last_beat;
    rdata   = reset ? '0 : rdata_q;
  end

  // rdata is loaded from whichever address the next presented beat uses:
  // the AR address directly when there is no wait, the latched address at
  // the end of the wait, or the advanced address after a non-last beat.
  always_comb begin
    rd_load = 1'b0;
    rd_addr = r_addr;
    case (r_state)
      R_IDLE: if (ar_fire && READ_LATENCY == 1) begin
        rd_load = 1'b1;
        rd_addr = araddr;
      end
      R_WAIT: if (lat_cnt == 4'd1) rd_load = 1'b1;
      R_DATA: if (r_fire && !r_last_beat) begin
        rd_load = 1'b1;
        rd_addr = next_addr(r_addr, r_size, r_burst);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      lat_cnt <= '0;
      rdata_q <= '0;
    end else begin
      if (ar_fire) begin
        r_addr  <= araddr;
        r_len   <= arlen;
        r_size  <= arsize;
        r_burst <= arburst;
        r_cnt   <= '0;
        lat_cnt <= 4'(READ_LATENCY - 1);
      end else if (r_state == R_WAIT) begin
        lat_cnt <= lat_cnt - 4'd1;
      end else if (r_fire && !r_last_beat) begin
        r_addr  <= rd_addr;
        r_cnt   <= r_cnt + 8'd1;
      end
      // Non-blocking read of mem gives the pre-write value on a same-edge
      // write to the same word.
      if (rd_load) rdata_q <= in_range(rd_addr) ? mem[word_idx(rd_addr)] : '0;
    end
  end

endmodule
